// File: rtl/conv_result_drain.sv
// conv_result_drain
//   Consumer side of the conv engine result interface. Each result tile
//   (PARA_X*PARA_Y elements) is captured on a result_ready pulse into one of
//   two ping-pong entries. The tile is then streamed out one element per
//   valid/ready beat, together with its feature-map write address.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   result_ready    1-cycle pulse: result_buffer / tile_base_addr / relu_en valid
//   result_buffer   tile, element k at [DW*(k+1)-1:DW*k]
//   tile_base_addr  address of element (0,0)
//   fmap_width      row stride of the output map (static during drain)
//   relu_en         per-tile ReLU on the FP16 sign bit
//   out_*           element stream (valid/ready), out_last on the final element
//   busy            either entry occupied
//   overrun         sticky: a tile arrived with both entries full and was dropped
module conv_result_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int PARA_X     = 3,
    parameter int PARA_Y     = 3,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                result_ready,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] result_buffer,
    input  logic [ADDR_WIDTH-1:0]               tile_base_addr,
    input  logic [ADDR_WIDTH-1:0]               fmap_width,
    input  logic                                relu_en,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [ADDR_WIDTH-1:0]               out_addr,
    output logic                                out_last,
    output logic                                busy,
    output logic                                overrun
);
    localparam int N  = PARA_X * PARA_Y;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int YW = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    typedef struct packed {
        logic [N*DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0]   base;
        logic                    relu;
    } entry_t;

    state_t          state;
    entry_t          ent [2];
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [KW-1:0]   k;
    logic [YW-1:0]   j2;
    logic [ADDR_WIDTH-1:0] row_addr;

    logic accept, free, cap_ok, load, ld_e;

    // Element select with optional ReLU; clearing on the sign bit also maps -0.0 to +0.0.
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [N*DATA_WIDTH-1:0] t,
                                                   input logic [KW-1:0] idx,
                                                   input logic relu);
        logic [DATA_WIDTH-1:0] e;
        e = t[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
        if (relu && e[DATA_WIDTH-1]) e = '0;
        return e;
    endfunction

    always_comb begin
        accept   = out_valid && out_ready;
        free     = accept && out_last;
        // Freeing is applied before the capture check so a tile arriving on the
        // same cycle the last beat is accepted still finds room.
        full_nxt = full;
        if (free) full_nxt[rd_ptr] = 1'b0;
        cap_ok   = result_ready && !full_nxt[wr_ptr];
        if (cap_ok) full_nxt[wr_ptr] = 1'b1;
        // Start a tile from IDLE, or back-to-back when the other entry is waiting.
        load = ((state == S_IDLE) && full[rd_ptr]) ||
               ((state == S_DRAIN) && free && full[~rd_ptr]);
        ld_e = (state == S_IDLE) ? rd_ptr : ~rd_ptr;
    end

    assign busy = |full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            full      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            k         <= '0;
            j2        <= '0;
            row_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
            ent[0]    <= '0;
            ent[1]    <= '0;
        end else begin
            full <= full_nxt;
            if (cap_ok) begin
                ent[wr_ptr] <= '{data: result_buffer, base: tile_base_addr, relu: relu_en};
                wr_ptr      <= ~wr_ptr;
            end
            if (result_ready && !cap_ok) overrun <= 1'b1;

            if (free) rd_ptr <= ~rd_ptr;

            if (load) begin
                state     <= S_DRAIN;
                out_valid <= 1'b1;
                k         <= '0;
                j2        <= '0;
                row_addr  <= ent[ld_e].base;
                out_addr  <= ent[ld_e].base;
                out_data  <= pick(ent[ld_e].data, '0, ent[ld_e].relu);
                out_last  <= (N == 1);
            end else if (free) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (accept) begin
                k        <= k + 1'b1;
                out_data <= pick(ent[rd_ptr].data, k + 1'b1, ent[rd_ptr].relu);
                out_last <= (k + 1'b1 == KW'(N - 1));
                // Row-major walk: column wraps to the next row at the map stride.
                if (j2 == YW'(PARA_Y - 1)) begin
                    j2       <= '0;
                    row_addr <= row_addr + fmap_width;
                    out_addr <= row_addr + fmap_width;
                end else begin
                    j2       <= j2 + 1'b1;
                    out_addr <= out_addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_result_drain.sv
module tb_conv_result_drain;
    localparam int DW = 16;
    localparam int PX = 3;
    localparam int PY = 3;
    localparam int AW = 12;
    localparam int N  = PX * PY;

    logic              clk = 0;
    logic              rst;
    logic              result_ready;
    logic [N*DW-1:0]   result_buffer;
    logic [AW-1:0]     tile_base_addr;
    logic [AW-1:0]     fmap_width;
    logic              relu_en;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_addr;
    logic              out_last;
    logic              busy;
    logic              overrun;

    conv_result_drain #(.DATA_WIDTH(DW), .PARA_X(PX), .PARA_Y(PY), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .result_ready(result_ready), .result_buffer(result_buffer),
        .tile_base_addr(tile_base_addr), .fmap_width(fmap_width), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .overrun(overrun));

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int    beat_cyc[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_beats = 0;
    int    cap_cyc = 0;
    bit    mon_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every presented beat is compared with the queue head; it is
    // only popped on acceptance, so a stalled beat must stay equal to the head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    e = exp_q[0];
                    chk("data", out_data, e.d);
                    chk("addr", out_addr, e.a);
                    chk("last", out_last, e.l);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_beats++;
                        beat_cyc.push_back(cyc);
                    end
                end
            end else if (out_last) chk("last_without_valid", out_last, 0);
        end
    end

    function automatic logic [N*DW-1:0] mk_tile(input logic [DW-1:0] v0);
        logic [N*DW-1:0] t;
        for (int i = 0; i < N; i++) t[i*DW +: DW] = v0 + DW'(i);
        return t;
    endfunction

    task automatic send_tile(input logic [N*DW-1:0] t, input logic [AW-1:0] base,
                             input logic rl, input bit acc);
        beat_t b;
        logic [DW-1:0] d;
        @(posedge clk); #1;
        result_buffer  = t;
        tile_base_addr = base;
        relu_en        = rl;
        result_ready   = 1;
        cap_cyc        = cyc;
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                d = t[i*DW +: DW];
                if (rl && d[DW-1]) d = '0;
                b.d = d;
                b.a = base + AW'(i / PY) * fmap_width + AW'(i % PY);
                b.l = (i == N - 1);
                exp_q.push_back(b);
            end
        end
        @(posedge clk); #1;
        result_ready = 0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain_timeout"}, (n >= 300), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; mon_en = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 0; mon_en = 1;
    endtask

    task automatic new_test();
        n_beats = 0;
        beat_cyc.delete();
    endtask

    logic [N*DW-1:0] t5;
    int n;

    initial begin
        rst = 1; result_ready = 0; result_buffer = '0; tile_base_addr = '0;
        fmap_width = 12'd8; relu_en = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0; mon_en = 1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // T1 single tile, base 10, stride 8
        new_test();
        send_tile(mk_tile(16'h3C00), 12'd10, 0, 1);
        wait_drain("t1");
        chk("t1_beats", n_beats, 9);
        if (beat_cyc.size() == 9) begin
            chk("t1_first_lat", beat_cyc[0] - cap_cyc, 2);
            chk("t1_last_lat", beat_cyc[8] - cap_cyc, 10);
        end else chk("t1_beatcount", beat_cyc.size(), 9);
        chk("t1_busy", busy, 0);

        // T2 backpressure 1,0,0 pattern
        new_test();
        out_ready = 1;
        send_tile(mk_tile(16'h4000), 12'd100, 0, 1);
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            out_ready = (n % 3 == 0);
            @(posedge clk); #1;
            n++;
        end
        chk("t2_timeout", (n >= 300), 0);
        chk("t2_beats", n_beats, 9);
        out_ready = 1;

        // T3 two tiles back to back; second base wraps past 2^AW
        new_test();
        send_tile(mk_tile(16'h1000), 12'd20, 0, 1);
        send_tile(mk_tile(16'h2000), 12'd4090, 0, 1);
        wait_drain("t3");
        chk("t3_beats", n_beats, 18);
        if (beat_cyc.size() == 18) chk("t3_contig", beat_cyc[17] - beat_cyc[0], 17);
        else chk("t3_beatcount", beat_cyc.size(), 18);

        // T4 overrun: third tile dropped while both entries full
        new_test();
        out_ready = 0;
        send_tile(mk_tile(16'h5000), 12'd0, 0, 1);
        send_tile(mk_tile(16'h6000), 12'd40, 0, 1);
        chk("t4_no_overrun_yet", overrun, 0);
        send_tile(mk_tile(16'h7000), 12'd80, 0, 0);
        @(negedge clk);
        chk("t4_overrun", overrun, 1);
        chk("t4_busy", busy, 1);
        @(posedge clk); #1 out_ready = 1;
        wait_drain("t4");
        chk("t4_beats", n_beats, 18);
        chk("t4_overrun_sticky", overrun, 1);
        chk("t4_busy_after", busy, 0);

        // T5 ReLU: negative values and -0.0 cleared
        new_test();
        t5 = mk_tile(16'h3C00);
        t5[0*DW +: DW] = 16'hBC00;
        t5[1*DW +: DW] = 16'h8000;
        t5[5*DW +: DW] = 16'hC200;
        send_tile(t5, 12'd200, 1, 1);
        wait_drain("t5");
        chk("t5_beats", n_beats, 9);

        // T6 reset mid-drain, then a clean tile
        do_reset();
        chk("t6_overrun_cleared", overrun, 0);
        new_test();
        send_tile(mk_tile(16'h0100), 12'd300, 0, 1);
        n = 0;
        while (n_beats < 4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_reach_beat4", (n >= 50), 0);
        rst = 1; mon_en = 0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t6_valid_after_rst", out_valid, 0);
        chk("t6_busy_after_rst", busy, 0);
        #1 rst = 0; mon_en = 1;
        new_test();
        send_tile(mk_tile(16'h0A00), 12'd500, 0, 1);
        wait_drain("t6");
        chk("t6_beats", n_beats, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
